// File: rtl/yuv422_conv_seq_if.sv
// Stream and converter-side signals of the 4:2:2 sequencer.
// slave = sequencer view, master = environment view.
interface yuv422_conv_seq_if;
  logic        cfg_709;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sof;
  logic [23:0] conv_yuv;
  logic        conv_select;
  logic [23:0] conv_bgr;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_bgr;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;

  modport master (
    output cfg_709, in_valid, in_data, in_sof,
    output conv_bgr, out_ready,
    input  in_ready, conv_yuv, conv_select,
    input  out_valid, out_bgr,
    input  out_sof, out_eol, out_eof
  );

  modport slave (
    input  cfg_709, in_valid, in_data, in_sof,
    input  conv_bgr, out_ready,
    output in_ready, conv_yuv, conv_select,
    output out_valid, out_bgr,
    output out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/yuv422_conv_seq.sv
// Splits packed YUV 4:2:2 pairs into two converter ops, one pixel/cycle out.
// Define YUV_SEQ_POSFLAGS_EN for x/y counters and out_eol/out_eof.
module yuv422_conv_seq #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 576
) (
  input logic             clk,
  input logic             reset_n,
  yuv422_conv_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_P0   = 2'd1,
    ST_P1   = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] word_q;
  logic        sof_q;
  logic        sel_q;
  logic [23:0] bgr_q;
  logic        valid_q;
  logic        osof_q;

  logic        slot_free;
  logic        load;
  logic        hs;
  logic        in_rdy;
  logic        accept;
  logic [23:0] yuv;

  assign slot_free = !valid_q || bus.out_ready;
  assign hs        = valid_q && bus.out_ready;
  assign load      = (state == ST_P0 || state == ST_P1)
                  && slot_free;
  assign accept    = bus.in_valid && in_rdy;

  // Ready and converter operand decode from state.
  always_comb begin
    in_rdy = 1'b0;
    yuv    = {word_q[31:24], word_q[23:16], word_q[7:0]};
    unique case (1'b1)
      (state == ST_IDLE): in_rdy = 1'b1;
      (state == ST_P1): begin
        in_rdy = slot_free;
        yuv    = {word_q[15:8], word_q[23:16], word_q[7:0]};
      end
      default: in_rdy = 1'b0;
    endcase
  end

  // Sequencer FSM with input word, matrix select and out register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      word_q  <= '0;
      sof_q   <= 1'b0;
      sel_q   <= 1'b0;
      bgr_q   <= '0;
      valid_q <= 1'b0;
      osof_q  <= 1'b0;
    end else begin
      if (accept) begin
        word_q <= bus.in_data;
        sof_q  <= bus.in_sof;
        if (bus.in_sof)
          sel_q <= bus.cfg_709;
      end
      if (load) begin
        bgr_q   <= bus.conv_bgr;
        valid_q <= 1'b1;
        osof_q  <= (state == ST_P0) ? sof_q : 1'b0;
      end else if (hs) begin
        valid_q <= 1'b0;
      end
      unique case (state)
        ST_IDLE:
          if (bus.in_valid) state <= ST_P0;
        ST_P0:
          if (slot_free) state <= ST_P1;
        ST_P1:
          if (slot_free)
            state <= bus.in_valid ? ST_P0 : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.conv_yuv    = yuv;
  assign bus.conv_select = sel_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_bgr     = bgr_q;
  assign bus.out_sof     = osof_q;

`ifdef YUV_SEQ_POSFLAGS_EN
  localparam int XW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // Position of the pixel held in the out register; sof resyncs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (load && state == ST_P0 && sof_q) begin
      x_q <= '0;
      y_q <= '0;
    end else if (hs) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  assign bus.out_eol = (x_q == X_LAST);
  assign bus.out_eof = (x_q == X_LAST) && (y_q == Y_LAST);
`else
  assign bus.out_eol = 1'b0;
  assign bus.out_eof = 1'b0;
`endif

endmodule

// File: doc/yuv422_conv_seq.md
# yuv422_conv_seq

- Sequencer that feeds the shared combinational YUV→BGR converter from a packed 4:2:2 pixel-pair stream.
- Each accepted input word is split into two converter operations: luma Y0, then Y1, each with the same U/V.
- Each converter result is registered and presented one pixel per cycle on a valid/ready output to the display backend.
- The block also owns the converter's colour-matrix select: the Rec.601/709 choice is latched only at frame start. It supplies frame-position flags.

## Interface
- WIDTH, 720: active pixels per line; must be even and ≥2.
- HEIGHT, 576: active lines per frame; must be ≥1.
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_709  in  1  matrix request: 0 = Rec.601, 1 = Rec.709.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  32  packed pair: [31:24] Y0, [23:16] U, [15:8] Y1, [7:0] V.
- in_sof  in  1  qualifies in_data as the first pair of a frame.
- conv_yuv  out  24  converter operand {Y, U, V}.
- conv_select  out  1  converter matrix select.
- conv_bgr  in  24  converter result, combinational from conv_yuv/conv_select.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accept.
- out_bgr  out  24  registered {B, G, R}.
- out_sof  out  1  output pixel is frame pixel 0.
- out_eol  out  1  output pixel is the last pixel of a line.
- out_eof  out  1  output pixel is the last pixel of the frame.

## Operation
- Registers: word_q[31:0], sof_q, conv_select, out register (out_bgr, out_valid, flags), FSM, and x/y counters.
- `slot_free` = !out_valid || out_ready.
- FSM state ST_IDLE:
  - in_ready = 1.
  - On in_valid: latch word_q and sof_q; go to ST_P0.
  - If in_sof, also latch conv_select ← cfg_709 on the same edge.
- FSM state ST_P0:
  - conv_yuv = {word_q[31:24], word_q[23:16], word_q[7:0]}; in_ready = 0.
  - If slot_free: load out_bgr ← conv_bgr, out_valid ← 1, out_sof ← sof_q; go to ST_P1.
- FSM state ST_P1:
  - conv_yuv = {word_q[15:8], word_q[23:16], word_q[7:0]}; in_ready = slot_free.
  - If slot_free: load the out register with out_sof ← 0.
  - Then, if in_valid, latch the new word (and conv_select if in_sof) and go to ST_P0; otherwise go to ST_IDLE.
- Output register:
  - Holds its value while out_valid && !out_ready.
  - Clears out_valid on a handshake when no new load occurs the same cycle.
- conv_select is never changed except on acceptance of an in_sof word.
- conv_yuv in ST_IDLE = {Y0, U, V} of word_q (don't-care to downstream, but deterministic).
- Flags come from x[$clog2(WIDTH)-1:0] and y[$clog2(HEIGHT)-1:0], which index the pixel currently in the out register:
  - out_eol = (x == WIDTH-1); out_eof = out_eol && (y == HEIGHT-1).
  - x advances on each output handshake, wrapping to 0 at WIDTH-1; when x wraps, y advances, wrapping to 0 at HEIGHT-1.
  - Loading a pixel with out_sof = 1 forces x = 0, y = 0 (resync overrides count).
- Reset:
  - All registers clear to 0: out_valid = 0, out_bgr = 0, flags = 0, conv_select = 0 (Rec.601), x = y = 0, FSM = ST_IDLE.
  - in_ready = 1 immediately on release.
  - Reset mid-pair discards the pending Y1.

## Timing
- Latency:
  - Word accepted at edge N.
  - Y0 pixel has out_valid = 1 from edge N+1, provided the out register is free in cycle N+1.
  - Y1 pixel follows one cycle later.
- Sustained throughput: one pixel per cycle (one word per two cycles) with out_ready held high.
- Backpressure: a stall holds the FSM state, word_q and the out register; no pixel is dropped or duplicated.
- A conv_select change is visible on conv_select the cycle after the in_sof edge, before that word's first conversion.

## Configuration
- YUV_SEQ_POSFLAGS_EN defined: x/y counters and out_eol/out_eof are implemented as above.
- YUV_SEQ_POSFLAGS_EN undefined:
  - Counters are omitted and out_eol = out_eof = 0.
  - out_sof and all sequencing are unchanged.

## Test plan
Bench model for the converter: conv_bgr = conv_yuv.
- Single word: in_data = 0x10802090, out_ready = 1 → out_bgr 0x108090 then 0x208090 on consecutive cycles, then out_valid = 0.
- Back-to-back words with out_ready = 1 → out_valid continuously 1, in_ready toggles 1/0, no gaps.
- out_ready low for 3 cycles while the Y0 pixel is presented → out_bgr stable at the Y0 value, in_ready = 0, and Y1 delivered after release.
- cfg_709 = 1 with in_sof = 1; cfg_709 toggled mid-frame → conv_select becomes 1 and holds until the next in_sof word.
- WIDTH = 4, HEIGHT = 2, 8 pixels → out_eol on pixels 3 and 7, out_eof on pixel 7, out_sof on pixel 0; with the macro undefined, eol/eof stay 0.
- reset_n asserted while in ST_P1 with out_valid = 1 → out_valid 0 asynchronously; after release in_ready = 1 and the next word restarts at Y0.
